set_job_dispatcher: RTL and testbench
=====================================

# set_job_dispatcher

Command front-end for the circle-set counting core. Buffers host jobs (centres, radii, mode, tag) in a small FIFO and issues them one at a time to the core over its en/busy/valid protocol. Captures each 8-bit candidate count and returns it with the job's tag on a valid/ready result port. A watchdog reports a core that never completes.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 4, job tag width
- TIMEOUT, 511, cycles from set_en until the job is declared failed
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO not full
- cmd_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each
- cmd_radius  in  12  {r1,r2,r3}
- cmd_mode  in  2  job mode, passed through unchanged
- cmd_tag  in  TAG_W  job tag
- set_en  out  1  one-cycle start pulse to core
- set_central  out  24  registered job centres
- set_radius  out  12  registered job radii
- set_mode  out  2  registered job mode
- set_busy  in  1  core busy
- set_valid  in  1  core result valid; level, held until the next start
- set_candidate  in  8  core count
- res_valid  out  1  result held
- res_ready  in  1  host accepts result
- res_candidate  out  8  count; 0 on error
- res_tag  out  TAG_W  tag of the completed job
- res_err  out  1  watchdog expired for this job
- jobs_done  out  16  completed jobs (incl. errored); wraps at 0xFFFF→0

## Operation
- FIFO: circular, DEPTH entries of {central, radius, mode, tag}, count register 0..DEPTH.
  - cmd_ready = (count != DEPTH).
  - Push on cmd_valid & cmd_ready.
  - Pop only on issue.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: an accepted command is issuable the next cycle.
- FSM states IDLE, ACK, RUN.
  - IDLE: if count != 0 and !res_valid → pop the head, register set_* from it, set_en<=1, wdog<=0, → ACK. Otherwise stay.
  - ACK: set_en<=0. If set_busy=1 → RUN. The stale set_valid from the previous job is ignored here.
  - RUN: if set_valid=1 & set_busy=0 → res_candidate<=set_candidate, res_tag<=job tag, res_err<=0, res_valid<=1, jobs_done+1 → IDLE.
- Watchdog: wdog increments every cycle in ACK and RUN. If wdog reaches TIMEOUT before completion:
  - res_candidate<=0, res_err<=1, res_valid<=1, jobs_done+1 → IDLE.
  - The core is not reset by this block.
- Result slot: res_valid clears on res_valid & res_ready. A held result blocks the next issue (IDLE waits on !res_valid).
- set_central, set_radius and set_mode hold their value between jobs.
- Mode is passed through unchanged; the block does not interpret it.

## Timing
- Reset values:
  - cmd_ready=1; set_en=0; set_central=0, set_radius=0, set_mode=0
  - res_valid=0, res_candidate=0, res_tag=0, res_err=0; jobs_done=0
  - FIFO empty; state IDLE; wdog=0
- Issue latency:
  - Command accepted at the edge ending cycle t → set_en high in cycle t+2 (empty FIFO, free result slot).
  - Core busy is expected in t+3.
- set_en is exactly one cycle wide; never asserted outside the IDLE→ACK transition.
- Result latency: completion seen in RUN at cycle c → res_valid high in c+1.
- Back-to-back throughput, with res_ready held 1:
  - result accepted in cycle r → IDLE in r+1 issues → set_en in r+2.
  - Dispatcher overhead is 3 cycles per job plus core time.
- rst mid-job: all state cleared immediately; the queued FIFO contents are lost; the in-flight result is dropped.
- A simultaneous FIFO push while the FSM pops in IDLE is legal.

## Test plan
- Single job, central x1=y1=4, r1=2, mode 0 (core or golden model attached), tag 5 → set_en pulses once at t+2; res_valid with res_candidate=13, res_tag=5, res_err=0; jobs_done=1.
- Four jobs pushed back-to-back, res_ready=1, tags 0..3 → 4th push leaves cmd_ready=0 for one cycle only if no pop occurred; results return in order with tags 0,1,2,3; exactly four set_en pulses; jobs_done=4.
- res_ready held 0 after the first result with 2 jobs queued → no further set_en while res_valid=1; release res_ready → next set_en exactly 2 cycles later.
- Stale valid: core leaves set_valid=1 from the prior job and asserts busy one cycle after set_en → no early capture; the result equals the new job's count.
- Stub core that never raises busy, TIMEOUT=16 → res_valid 17 cycles after set_en with res_err=1, res_candidate=0; FSM returns to IDLE and issues the next queued job.
- rst pulsed while in RUN with 3 jobs queued → all outputs at reset values next cycle, cmd_ready=1, no res_valid; a new job after reset completes normally.

Source files
------------

// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: queues host jobs, issues them to the circle-set core, returns tagged counts with a watchdog
module set_job_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TIMEOUT = 511
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [23:0]      cmd_central,
  input  logic [11:0]      cmd_radius,
  input  logic [1:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [15:0]      jobs_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACK, RUN} state_t;
  state_t state, state_n;
  logic [23:0] mem_c [DEPTH];
  logic [11:0] mem_r [DEPTH];
  logic [1:0] mem_m [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WW-1:0] wdog;
  logic [TAG_W-1:0] job_tag;
  logic push, issue, done, expire;
  assign cmd_ready = count != FULL;
  assign push = cmd_valid && cmd_ready;
  // a stale set_valid in ACK is ignored: completion only counts in RUN with busy low
  always_comb begin
    issue = state == IDLE && count != '0 && !res_valid;
    done = state == RUN && set_valid && !set_busy;
    expire = state != IDLE && !done && wdog == LIMIT;
    state_n = state;
    if (issue) state_n = ACK;
    else if (done || expire) state_n = IDLE;
    else if (state == ACK && set_busy) state_n = RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) begin
      mem_c[wr_ptr] <= cmd_central;
      mem_r[wr_ptr] <= cmd_radius;
      mem_m[wr_ptr] <= cmd_mode;
      mem_t[wr_ptr] <= cmd_tag;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wdog <= '0;
      set_en <= 1'b0;
      set_central <= '0;
      set_radius <= '0;
      set_mode <= '0;
      job_tag <= '0;
      res_valid <= 1'b0;
      res_candidate <= '0;
      res_tag <= '0;
      res_err <= 1'b0;
      jobs_done <= '0;
    end else begin
      set_en <= issue;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(issue);
      count <= count + (AW+1)'(push) - (AW+1)'(issue);
      wdog <= issue ? '0 : state != IDLE ? wdog + 1'b1 : wdog;
      if (issue) begin
        set_central <= mem_c[rd_ptr];
        set_radius <= mem_r[rd_ptr];
        set_mode <= mem_m[rd_ptr];
        job_tag <= mem_t[rd_ptr];
      end
      if (done || expire) begin
        res_valid <= 1'b1;
        res_candidate <= done ? set_candidate : '0;
        res_err <= expire;
        res_tag <= job_tag;
        jobs_done <= jobs_done + 16'd1;
      end else if (res_ready) res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_set_job_dispatcher.sv
// tb_set_job_dispatcher: table-driven jobs against a stub core, scoreboarded results and corner sequences
module tb_set_job_dispatcher;
  localparam int TAG_W = 4;
  logic clk, rst;
  logic cmd_valid, cmd_ready;
  logic [23:0] cmd_central;
  logic [11:0] cmd_radius;
  logic [1:0] cmd_mode;
  logic [TAG_W-1:0] cmd_tag;
  logic set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0] set_mode;
  logic set_busy, set_valid;
  logic [7:0] set_candidate;
  logic res_valid, res_ready;
  logic [7:0] res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic res_err;
  logic [15:0] jobs_done;

  set_job_dispatcher #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_central(cmd_central),
    .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_err(res_err), .jobs_done(jobs_done)
  );

  typedef struct {
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0] m;
    logic [3:0] t;
    logic [7:0] exp;
  } vec_t;
  typedef struct {
    logic [3:0] t;
    logic [7:0] cand;
    logic err;
  } res_t;
  vec_t tv[6];
  res_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, en_total = 0, en_cyc = -1, rise_cyc = -1, last_push_cyc = 0;
  logic hang, prev_en, prev_rv;
  int stub_left;
  logic stub_pend;
  logic [7:0] stub_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // stub core: counts 16x16 grid points inside circle 1, offset by mode*64
  function automatic logic [7:0] core_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int n, x1, y1, rr;
    n = 0;
    x1 = int'(c[23:20]);
    y1 = int'(c[19:16]);
    rr = int'(r[11:8]);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if ((x - x1) * (x - x1) + (y - y1) * (y - y1) <= rr * rr) n++;
    return 8'(n + int'(m) * 64);
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // core stub: busy one cycle after set_en, three busy cycles, valid/candidate held until next completion
  initial begin
    set_busy = 0; set_valid = 0; set_candidate = 0;
    stub_left = 0; stub_pend = 0; stub_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        set_busy = 0; set_valid = 0; set_candidate = 0; stub_pend = 0; stub_left = 0;
      end else begin
        if (stub_left > 0) begin
          stub_left--;
          if (stub_left == 0) begin set_busy = 0; set_valid = 1; set_candidate = stub_cnt; end
        end else if (stub_pend) begin
          stub_pend = 0; set_busy = 1; stub_left = 3;
        end
        if (set_en) begin
          stub_pend = !hang;
          stub_cnt = core_count(set_central, set_radius, set_mode);
        end
      end
    end
  end

  initial begin
    res_t e;
    prev_en = 0; prev_rv = 0;
    forever begin
      @(negedge clk);
      if (set_en) begin
        en_total++;
        en_cyc = cyc;
        chk("set_en_width", 32'(prev_en), 0);
      end
      if (res_valid && !prev_rv) rise_cyc = cyc;
      if (res_valid && res_ready && !rst) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got tag %0d cand %0d, required no result", res_tag, res_candidate);
        end else begin
          e = sb.pop_front();
          chk("res_tag", 32'(res_tag), 32'(e.t));
          chk("res_candidate", 32'(res_candidate), 32'(e.cand));
          chk("res_err", 32'(res_err), 32'(e.err));
        end
      end
      prev_en = set_en;
      prev_rv = res_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic push(input int i, input logic err);
    int n;
    logic acc;
    n = 0;
    acc = 0;
    cmd_valid = 1;
    cmd_central = tv[i].c;
    cmd_radius = tv[i].r;
    cmd_mode = tv[i].m;
    cmd_tag = tv[i].t;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = cmd_ready;
      last_push_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    chk("push_accept", 32'(acc), 1);
    sb.push_back(res_t'{tv[i].t, err ? 8'd0 : tv[i].exp, err});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 0);
  endtask

  task automatic check_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_set_en", 32'(set_en), 0);
    chk("rst_set_central", 32'(set_central), 0);
    chk("rst_set_radius", 32'(set_radius), 0);
    chk("rst_set_mode", 32'(set_mode), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_candidate", 32'(res_candidate), 0);
    chk("rst_res_tag", 32'(res_tag), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_jobs_done", 32'(jobs_done), 0);
  endtask

  initial begin
    int n, t, r, s, n0, n1;
    tv[0] = '{24'h44A5C3, 12'h237, 2'd0, 4'd5, 8'd13};
    tv[1] = '{24'h001234, 12'h100, 2'd0, 4'd0, 8'd3};
    tv[2] = '{24'h790000, 12'h0FF, 2'd1, 4'd1, 8'd65};
    tv[3] = '{24'h00FFFF, 12'h211, 2'd2, 4'd2, 8'd134};
    tv[4] = '{24'h885A5A, 12'h1EE, 2'd3, 4'd3, 8'd197};
    tv[5] = '{24'hFF0102, 12'h234, 2'd0, 4'd9, 8'd6};
    rst = 1; hang = 0; res_ready = 1;
    cmd_valid = 0; cmd_central = 0; cmd_radius = 0; cmd_mode = 0; cmd_tag = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    // single job: set_en two cycles after acceptance
    n0 = en_total;
    push(0, 0);
    cmd_valid = 0;
    t = last_push_cyc;
    for (n = 0; n < 20 && en_total == n0; n++) @(posedge clk);
    #1;
    chk("issue_latency", 32'(en_cyc - t), 2);
    drain();
    chk("single_en_count", 32'(en_total - n0), 1);
    chk("single_jobs_done", 32'(jobs_done), 1);
    // four jobs back-to-back from the table, results in order
    n0 = en_total;
    for (int i = 1; i <= 4; i++) push(i, 0);
    cmd_valid = 0;
    drain();
    chk("burst_en_count", 32'(en_total - n0), 4);
    chk("burst_jobs_done", 32'(jobs_done), 5);
    chk("burst_cmd_ready", 32'(cmd_ready), 1);
    // held result blocks issue until accepted
    res_ready = 0;
    push(5, 0);
    push(0, 0);
    push(1, 0);
    cmd_valid = 0;
    for (n = 0; n < 40 && !res_valid; n++) @(posedge clk);
    #1;
    chk("hold_res_valid_seen", 32'(res_valid), 1);
    n1 = en_total;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_no_issue", 32'(en_total), 32'(n1));
    chk("hold_res_valid", 32'(res_valid), 1);
    res_ready = 1;
    r = cyc;
    for (n = 0; n < 20 && en_total == n1; n++) @(posedge clk);
    #1;
    chk("release_latency", 32'(en_cyc - r), 2);
    drain();
    chk("hold_jobs_done", 32'(jobs_done), 8);
    // watchdog: core never goes busy, next queued job still runs
    hang = 1;
    n0 = en_total;
    push(2, 1);
    cmd_valid = 0;
    for (n = 0; n < 20 && en_total == n0; n++) @(posedge clk);
    #1;
    hang = 0;
    s = en_cyc;
    push(3, 0);
    cmd_valid = 0;
    for (n = 0; n < 40 && rise_cyc <= s; n++) @(posedge clk);
    #1;
    chk("timeout_latency", 32'(rise_cyc - s), 17);
    drain();
    chk("timeout_jobs_done", 32'(jobs_done), 10);
    // reset while a job runs with three queued behind it
    for (int i = 1; i <= 4; i++) push(i, 0);
    cmd_valid = 0;
    for (n = 0; n < 20 && !set_busy; n++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    sb.delete();
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 0;
    n0 = en_total;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_no_issue", 32'(en_total), 32'(n0));
    chk("post_rst_res_valid", 32'(res_valid), 0);
    chk("post_rst_jobs_done", 32'(jobs_done), 0);
    push(0, 0);
    cmd_valid = 0;
    drain();
    chk("post_rst_en_count", 32'(en_total - n0), 1);
    chk("post_rst_job", 32'(jobs_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
